// File: rtl/trap_control.sv
// Machine-mode trap sequencer: accepts interrupts, exceptions and MRET from
// decode, then writes mepc/mcause and redirects fetch over a fixed number of cycles.
module trap_control #(
    parameter int XLEN           = 32,
    parameter int NUM_IRQ        = 4,
    parameter int IRQ_CAUSE_BASE = 16
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_valid,
    input  logic               I_ecall,
    input  logic               I_ebreak,
    input  logic               I_illegalinst,
    input  logic               I_mret,
    input  logic [XLEN-1:0]    I_pc,
    input  logic [NUM_IRQ-1:0] I_irq,
    input  logic [NUM_IRQ-1:0] I_irqmask,
    input  logic               I_mie,
    input  logic [XLEN-1:0]    I_mtvec,
    input  logic [XLEN-1:0]    I_mepc,
    output logic               O_stall,
    output logic               O_csrwen,
    output logic [11:0]        O_csraddr,
    output logic [XLEN-1:0]    O_csrwdata,
    output logic               O_redirect,
    output logic [XLEN-1:0]    O_target,
    output logic               O_mieclear,
    output logic               O_mierestore,
    output logic               O_busy
);

    // state      | meaning
    // IDLE       | waiting for a valid instruction carrying an event
    // SAVE_EPC   | writing latched PC to mepc
    // SAVE_CAUSE | writing latched cause to mcause, clearing MIE
    // VECTOR     | redirecting fetch to the trap vector
    // RETURN     | redirecting fetch to mepc, restoring MIE
    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_CAUSE,
        VECTOR,
        RETURN
    } state_t;

    localparam logic [11:0]     CSR_MEPC   = 12'h341;
    localparam logic [11:0]     CSR_MCAUSE = 12'h342;
    localparam logic [XLEN-1:0] CAUSE_INTR = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] CAUSE_ILL  = XLEN'(2);
    localparam logic [XLEN-1:0] CAUSE_BRK  = XLEN'(3);
    localparam logic [XLEN-1:0] CAUSE_ECL  = XLEN'(11);

    state_t             state;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    cause_q;

    logic [NUM_IRQ-1:0] irq_pend;
    logic               irq_hit;
    logic [4:0]         irq_idx;
    logic               idle_ok;
    logic               trap_evt;
    logic               accept_trap;
    logic               accept_mret;
    logic [XLEN-1:0]    trap_cause;

    logic               unused_addr_bits;
    assign unused_addr_bits = ^{I_mtvec[1:0], I_mepc[0]};

    assign irq_pend = I_mie ? (I_irq & I_irqmask) : '0;

    // Scan downward so the lowest pending line is the last one written.
    always_comb begin
        irq_hit = 1'b0;
        irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_pend[i]) begin
                irq_hit = 1'b1;
                irq_idx = 5'(i);
            end
        end
    end

    always_comb begin
        idle_ok     = (state == IDLE) && I_valid && !I_rst;
        trap_evt    = irq_hit || I_illegalinst || I_ebreak || I_ecall;
        accept_trap = idle_ok && trap_evt;
        accept_mret = idle_ok && !trap_evt && I_mret;
        if (irq_hit) begin
            trap_cause = CAUSE_INTR | (XLEN'(IRQ_CAUSE_BASE) + XLEN'(irq_idx));
        end else if (I_illegalinst) begin
            trap_cause = CAUSE_ILL;
        end else if (I_ebreak) begin
            trap_cause = CAUSE_BRK;
        end else begin
            trap_cause = CAUSE_ECL;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state   <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_trap) begin
                        pc_q    <= I_pc;
                        cause_q <= trap_cause;
                        state   <= SAVE_EPC;
                    end else if (accept_mret) begin
                        state <= RETURN;
                    end
                end
                SAVE_EPC:   state <= SAVE_CAUSE;
                SAVE_CAUSE: state <= VECTOR;
                VECTOR:     state <= IDLE;
                RETURN:     state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state register and are forced low in reset.
    always_comb begin
        O_csrwen     = 1'b0;
        O_csraddr    = '0;
        O_csrwdata   = '0;
        O_redirect   = 1'b0;
        O_target     = '0;
        O_mieclear   = 1'b0;
        O_mierestore = 1'b0;
        O_busy       = 1'b0;
        O_stall      = 1'b0;
        if (!I_rst) begin
            O_busy  = (state != IDLE);
            O_stall = (state != IDLE) || accept_trap || accept_mret;
            case (state)
                SAVE_EPC: begin
                    O_csrwen   = 1'b1;
                    O_csraddr  = CSR_MEPC;
                    O_csrwdata = pc_q;
                end
                SAVE_CAUSE: begin
                    O_csrwen   = 1'b1;
                    O_csraddr  = CSR_MCAUSE;
                    O_csrwdata = cause_q;
                    O_mieclear = 1'b1;
                end
                VECTOR: begin
                    O_redirect = 1'b1;
                    O_target   = {I_mtvec[XLEN-1:2], 2'b00};
                end
                RETURN: begin
                    O_redirect   = 1'b1;
                    O_target     = {I_mepc[XLEN-1:1], 1'b0};
                    O_mierestore = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_control.sv
// Directed bench for trap_control: expected per-cycle output records are queued
// as stimulus is applied and compared against the DUT one cycle at a time.
module tb_trap_control;

    typedef struct packed {
        logic        stall;
        logic        busy;
        logic        csrwen;
        logic [11:0] csraddr;
        logic [31:0] csrwdata;
        logic        redirect;
        logic [31:0] target;
        logic        mieclear;
        logic        mierestore;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, ecall, ebreak, illegal, mret, mie;
    logic [31:0] pc, mtvec, mepc;
    logic [3:0]  irq, irqmask;

    logic        stall, csrwen, redirect, mieclear, mierestore, busy;
    logic [11:0] csraddr;
    logic [31:0] csrwdata, target;

    rec_t  sb[$];
    int    compared = 0;
    int    mismatched = 0;
    string tag = "";

    trap_control #(.XLEN(32), .NUM_IRQ(4), .IRQ_CAUSE_BASE(16)) dut (
        .I_clk(clk), .I_rst(rst), .I_valid(valid), .I_ecall(ecall),
        .I_ebreak(ebreak), .I_illegalinst(illegal), .I_mret(mret),
        .I_pc(pc), .I_irq(irq), .I_irqmask(irqmask), .I_mie(mie),
        .I_mtvec(mtvec), .I_mepc(mepc),
        .O_stall(stall), .O_csrwen(csrwen), .O_csraddr(csraddr),
        .O_csrwdata(csrwdata), .O_redirect(redirect), .O_target(target),
        .O_mieclear(mieclear), .O_mierestore(mierestore), .O_busy(busy)
    );

    always #5 clk = ~clk;

    function automatic rec_t r_idle(input logic st);
        rec_t r = '0;
        r.stall = st;
        return r;
    endfunction

    function automatic rec_t r_csr(input logic [11:0] a, input logic [31:0] d, input logic clr);
        rec_t r = '0;
        r.stall = 1'b1; r.busy = 1'b1; r.csrwen = 1'b1;
        r.csraddr = a; r.csrwdata = d; r.mieclear = clr;
        return r;
    endfunction

    function automatic rec_t r_redir(input logic [31:0] t, input logic rest);
        rec_t r = '0;
        r.stall = 1'b1; r.busy = 1'b1; r.redirect = 1'b1;
        r.target = t; r.mierestore = rest;
        return r;
    endfunction

    function automatic logic [31:0] irq_cause(input logic [3:0] lines);
        for (int i = 0; i < 4; i++)
            if (lines[i]) return 32'h8000_0000 | (32'd16 + 32'(i));
        return 32'h0;
    endfunction

    task automatic push_trap(input logic [31:0] cause);
        sb.push_back(r_idle(1'b1));
        sb.push_back(r_csr(12'h341, pc, 1'b0));
        sb.push_back(r_csr(12'h342, cause, 1'b1));
        sb.push_back(r_redir(mtvec & 32'hFFFF_FFFC, 1'b0));
    endtask

    task automatic clear_events();
        ecall = 0; ebreak = 0; illegal = 0; mret = 0; irq = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
    task automatic cycle();
        rec_t obs, exp;
        @(negedge clk);
        exp = sb.pop_front();
        obs = {stall, busy, csrwen, csraddr, csrwdata, redirect, target, mieclear, mierestore};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed stall=%b busy=%b wen=%b addr=%h wdata=%h redir=%b tgt=%h clr=%b rst=%b expected stall=%b busy=%b wen=%b addr=%h wdata=%h redir=%b tgt=%h clr=%b rst=%b",
                   tag, obs.stall, obs.busy, obs.csrwen, obs.csraddr, obs.csrwdata, obs.redirect,
                   obs.target, obs.mieclear, obs.mierestore, exp.stall, exp.busy, exp.csrwen,
                   exp.csraddr, exp.csrwdata, exp.redirect, exp.target, exp.mieclear, exp.mierestore);
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model: predicts the whole response to the currently driven inputs.
    task automatic run_event(input string name);
        logic [3:0] pend;
        tag  = name;
        pend = mie ? (irq & irqmask) : 4'b0;
        if (!valid)            sb.push_back(r_idle(1'b0));
        else if (pend != 4'b0) push_trap(irq_cause(pend));
        else if (illegal)      push_trap(32'd2);
        else if (ebreak)       push_trap(32'd3);
        else if (ecall)        push_trap(32'd11);
        else if (mret) begin
            sb.push_back(r_idle(1'b1));
            sb.push_back(r_redir(mepc & 32'hFFFF_FFFE, 1'b1));
        end else               sb.push_back(r_idle(1'b0));
        cycle();
        clear_events();
        while (sb.size() > 0) cycle();
    endtask

    initial begin
        rst = 1; valid = 0; mie = 0; irqmask = '0;
        pc = '0; mtvec = '0; mepc = '0;
        clear_events();
        @(posedge clk); #1;

        tag = "reset_idle";
        sb.push_back(r_idle(1'b0)); cycle();
        tag = "reset_with_event";
        valid = 1; ecall = 1;
        sb.push_back(r_idle(1'b0)); cycle();
        rst = 0; valid = 0;
        run_event("invalid_ecall");
        ecall = 0;

        valid = 1; ecall = 1; pc = 32'h80; mtvec = 32'h101;
        run_event("ecall_basic");

        mie = 1; irq = 4'b1010; irqmask = 4'b1000; illegal = 1; pc = 32'h1234; mtvec = 32'h2002;
        run_event("irq3_over_illegal");

        ebreak = 1; ecall = 1; mret = 1; pc = 32'h400;
        run_event("ebreak_over_ecall_mret");

        mie = 0; irq = 4'b1111; irqmask = 4'b1111; illegal = 1; pc = 32'h500;
        run_event("illegal_mie_off");

        mret = 1; mepc = 32'h205;
        run_event("mret_basic");

        mie = 1; irq = 4'b0011; irqmask = 4'b1111; ecall = 1; pc = 32'h600;
        run_event("irq0_lowest");

        irq = 4'b1111; irqmask = 4'b0000;
        run_event("irq_masked_idle");

        valid = 0; mret = 1;
        run_event("mret_invalid");
        valid = 1;

        // Reset during SAVE_CAUSE must abort the sequence.
        tag = "rst_mid_seq"; ecall = 1; pc = 32'h700; mtvec = 32'h800;
        sb.push_back(r_idle(1'b1)); cycle();
        clear_events();
        sb.push_back(r_csr(12'h341, 32'h700, 1'b0)); cycle();
        rst = 1;
        sb.push_back(r_idle(1'b0)); cycle();
        rst = 0;
        sb.push_back(r_idle(1'b0)); cycle();
        sb.push_back(r_idle(1'b0)); cycle();

        // ebreak raised during VECTOR is dropped; masked interrupt not taken afterwards.
        tag = "ebreak_while_busy"; ecall = 1; pc = 32'h900; mtvec = 32'hA00;
        sb.push_back(r_idle(1'b1)); cycle();
        clear_events();
        sb.push_back(r_csr(12'h341, 32'h900, 1'b0)); cycle();
        sb.push_back(r_csr(12'h342, 32'd11, 1'b1)); cycle();
        ebreak = 1;
        sb.push_back(r_redir(32'hA00, 1'b0)); cycle();
        ebreak = 0; mie = 0; irq = 4'b1111; irqmask = 4'b1111;
        tag = "irq_mie_off_idle";
        sb.push_back(r_idle(1'b0)); cycle();
        sb.push_back(r_idle(1'b0)); cycle();
        clear_events();

        for (int k = 0; k < 10; k++) begin
            valid   = 1'($urandom_range(0, 3) != 0);
            ecall   = 1'($urandom_range(0, 1));
            ebreak  = 1'($urandom_range(0, 1));
            illegal = 1'($urandom_range(0, 1));
            mret    = 1'($urandom_range(0, 1));
            mie     = 1'($urandom_range(0, 1));
            irq     = 4'($urandom_range(0, 15));
            irqmask = 4'($urandom_range(0, 15));
            pc      = $urandom;
            mtvec   = $urandom;
            mepc    = $urandom;
            run_event("random_mix");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/trap_control.md
TRAP_CONTROL -- requirements
Module: trap_control

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of PC and CSR data paths.
REQ-002 SHALL have parameter NUM_IRQ, default 4, range 1-16: number of external interrupt lines.
REQ-003 SHALL have parameter IRQ_CAUSE_BASE, default 16: mcause code of interrupt line 0.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
- I_clk  in  1  single clock; all state changes on its rising edge.
- I_rst  in  1  synchronous, active-high reset.
- I_valid  in  1  the current instruction is valid and may retire this cycle.
- I_ecall  in  1  decoder exception flag.
- I_ebreak  in  1  decoder exception flag.
- I_illegalinst  in  1  decoder exception flag.
- I_mret  in  1  decoded MRET.
- I_pc  in  XLEN  PC of the current instruction.
- I_irq  in  NUM_IRQ  level-sensitive interrupt requests.
- I_irqmask  in  NUM_IRQ  per-line enable (mie bits).
- I_mie  in  1  global interrupt enable (mstatus.MIE).
- I_mtvec  in  XLEN  trap vector base.
- I_mepc  in  XLEN  current mepc CSR value.
- O_stall  out  1  freeze fetch and decode.
- O_csrwen  out  1  CSR write strobe.
- O_csraddr  out  12  CSR address for the write.
- O_csrwdata  out  XLEN  CSR write data.
- O_redirect  out  1  one-cycle pulse; the PC loads O_target.
- O_target  out  XLEN  redirect target.
- O_mieclear  out  1  pulse; save MIE to MPIE and clear MIE.
- O_mierestore  out  1  pulse; restore MIE from MPIE.
- O_busy  out  1  FSM is not in IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, SAVE_EPC, SAVE_CAUSE, VECTOR, RETURN.
REQ-006 In IDLE with I_valid=1, SHALL select one event in this priority order: interrupt, illegal, ebreak, ecall, mret.
REQ-007 An interrupt SHALL be pending when I_mie=1 and (I_irq & I_irqmask) is non-zero.
REQ-008 Among pending interrupt lines, the lowest index SHALL win.
REQ-009 On accepting any trap (interrupt, illegal, ebreak, ecall), SHALL latch I_pc and the cause, then go to SAVE_EPC.
REQ-010 Cause encoding: interrupt = MSB 1 with low bits IRQ_CAUSE_BASE+index; illegal = 2; ebreak = 3; ecall = 11; non-interrupt causes have MSB 0.
REQ-011 SAVE_EPC SHALL drive O_csrwen=1, O_csraddr=0x341, O_csrwdata=latched PC, then go to SAVE_CAUSE.
REQ-012 SAVE_CAUSE SHALL drive O_csrwen=1, O_csraddr=0x342, O_csrwdata=latched cause, O_mieclear=1, then go to VECTOR.
REQ-013 VECTOR SHALL pulse O_redirect=1 with O_target={I_mtvec[XLEN-1:2],2'b00}, then go to IDLE.
REQ-014 MRET accepted in IDLE SHALL go to RETURN.
REQ-015 RETURN SHALL pulse O_redirect=1 with O_target={I_mepc[XLEN-1:1],1'b0} and O_mierestore=1, then go to IDLE.
REQ-016 Latency SHALL be: trap acceptance to redirect = 3 cycles (SAVE_EPC, SAVE_CAUSE, VECTOR); mret acceptance to redirect = 1 cycle.
REQ-017 O_stall SHALL be combinationally high in the acceptance cycle and in every non-IDLE state; the trapping instruction SHALL NOT retire.
REQ-018 O_busy SHALL be high exactly when the state is not IDLE.
REQ-019 All event inputs SHALL be ignored while O_busy=1; interrupts are not latched and are re-evaluated on return to IDLE.
REQ-020 With I_valid=0, SHALL accept nothing and hold IDLE.
REQ-021 Simultaneous flags SHALL be resolved by REQ-006 only; lower-priority flags are dropped, not queued.
REQ-022 O_csrwen, O_redirect, O_mieclear and O_mierestore SHALL each be high for exactly one cycle per event; O_csraddr, O_csrwdata and O_target SHALL be 0 when their strobe is low.

Reset
REQ-023 With I_rst=1 at a clock edge, SHALL enter IDLE and clear the latched PC and cause, regardless of current state.
REQ-024 While I_rst=1, all outputs SHALL be 0.
REQ-025 Reset mid-sequence SHALL abort with no further CSR writes or redirect.

Verification
REQ-026 I_valid=1, I_ecall=1, I_pc=0x80, I_mtvec=0x101 -> cycle 1: write 0x341/0x80; cycle 2: write 0x342/11 plus mieclear; cycle 3: redirect to 0x100.
REQ-027 I_mie=1, I_irq=4'b1010, I_irqmask=4'b1000, I_illegalinst=1 -> cause 0x80000013 (line 3); the illegal flag is dropped.
REQ-028 I_mret=1, I_mepc=0x205 -> next cycle redirect to 0x204 with mierestore=1 and no CSR write.
REQ-029 I_rst asserted in SAVE_CAUSE -> next cycle IDLE with all outputs 0; no redirect follows.
REQ-030 I_ebreak asserted during VECTOR, then I_mie=0 with I_irq all high in IDLE -> ebreak ignored while busy; the interrupt is not taken; O_stall=0.
